// File: rtl/tdm_demux_2ch.sv
// Receive side of the 2-channel TDM link: deframes the bit-serial stream,
// checks even parity and steers each good payload to its channel register.
module tdm_demux_2ch #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              din,
  output logic [DATA_W-1:0] O0,
  output logic [DATA_W-1:0] O1,
  output logic              v0,
  output logic              v1,
  output logic              perr,
  output logic              abrt,
  output logic              busy,
  output logic [CNT_W-1:0]  frm_cnt
);

  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_sel;
  logic                r_par;
  logic [DATA_W-1:0]   r_shift;
  logic [BW-1:0]       r_bitCnt;
  logic [DATA_W-1:0]   r_o0;
  logic [DATA_W-1:0]   r_o1;
  logic                r_v0;
  logic                r_v1;
  logic                r_perr;
  logic                r_abrt;
  logic                r_busy;
  logic [CNT_W-1:0]    r_frmCnt;

  // A qualified sync always (re)starts a frame; it only counts as an abort
  // when it cuts into a frame that was already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= 1'b0;
      r_par    <= 1'b0;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_o0     <= '0;
      r_o1     <= '0;
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_perr   <= 1'b0;
      r_abrt   <= 1'b0;
      r_busy   <= 1'b0;
      r_frmCnt <= '0;
    end else begin
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_perr <= 1'b0;
      r_abrt <= 1'b0;
      if (en) begin
        if (sync) begin
          r_abrt   <= (r_state != IDLE);
          r_sel    <= din;
          r_par    <= din;
          r_shift  <= '0;
          r_bitCnt <= '0;
          r_state  <= DATA;
          r_busy   <= 1'b1;
        end else begin
          case (r_state)
            IDLE: begin
              r_state <= IDLE;
            end
            DATA: begin
              r_shift  <= {r_shift[DATA_W-2:0], din};
              r_par    <= r_par ^ din;
              r_bitCnt <= r_bitCnt + BW'(1);
              if (r_bitCnt == BW'(DATA_W - 1)) begin
                r_state <= PAR;
              end
            end
            PAR: begin
              if (r_par ^ din) begin
                r_perr <= 1'b1;
              end else begin
                if (r_sel) begin
                  r_o1 <= r_shift;
                  r_v1 <= 1'b1;
                end else begin
                  r_o0 <= r_shift;
                  r_v0 <= 1'b1;
                end
                if (r_frmCnt != {CNT_W{1'b1}}) begin
                  r_frmCnt <= r_frmCnt + CNT_W'(1);
                end
              end
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
            default: begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign O0      = r_o0;
  assign O1      = r_o1;
  assign v0      = r_v0;
  assign v1      = r_v1;
  assign perr    = r_perr;
  assign abrt    = r_abrt;
  assign busy    = r_busy;
  assign frm_cnt = r_frmCnt;

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Scoreboard bench for tdm_demux_2ch: a second instance with a 2-bit
// counter shares the stimulus so counter saturation is observed too.
module tb_tdm_demux_2ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       din = 1'b0;

  logic [7:0] O0, O1, frm_cnt;
  logic       v0, v1, perr, abrt, busy;
  logic [7:0] sO0, sO1;
  logic       sV0, sV1, sPerr, sAbrt, sBusy;
  logic [1:0] sCnt;

  typedef struct {
    logic [3:0] flags;
    logic [7:0] o0;
    logic [7:0] o1;
    logic [7:0] cnt;
    logic [1:0] sat;
    logic       busy;
  } exp_t;

  exp_t       q[$];
  exp_t       mon;
  int         nChecks = 0;
  int         nFails = 0;
  logic [7:0] mO0 = 8'h00;
  logic [7:0] mO1 = 8'h00;
  logic [7:0] mCnt = 8'h00;
  logic [1:0] mSat = 2'd0;

  tdm_demux_2ch #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .O0(O0), .O1(O1), .v0(v0), .v1(v1), .perr(perr), .abrt(abrt),
    .busy(busy), .frm_cnt(frm_cnt)
  );

  tdm_demux_2ch #(.DATA_W(8), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .O0(sO0), .O1(sO1), .v0(sV0), .v1(sV1), .perr(sPerr), .abrt(sAbrt),
    .busy(sBusy), .frm_cnt(sCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (v0 || v1 || perr || abrt) begin
      if (q.size() == 0) begin
        checkOutput("unexpectedPulse", {28'd0, v0, v1, perr, abrt}, 32'd0);
      end else begin
        mon = q.pop_front();
        checkOutput("pulseFlags", {28'd0, v0, v1, perr, abrt}, {28'd0, mon.flags});
        checkOutput("O0", {24'd0, O0}, {24'd0, mon.o0});
        checkOutput("O1", {24'd0, O1}, {24'd0, mon.o1});
        checkOutput("frmCnt", {24'd0, frm_cnt}, {24'd0, mon.cnt});
        checkOutput("frmCntSat", {30'd0, sCnt}, {30'd0, mon.sat});
        checkOutput("busy", {31'd0, busy}, {31'd0, mon.busy});
      end
    end
  end

  task automatic sendBit(input logic s, input logic d, input bit toggle);
    @(posedge clk);
    #1;
    en = 1'b1;
    sync = s;
    din = d;
    if (toggle) begin
      @(posedge clk);
      #1;
      en = 1'b0;
      sync = 1'($urandom);
      din = 1'($urandom);
    end
  endtask

  task automatic sendPartial(input logic s, input logic [7:0] data, input int nBits, input bit toggle);
    sendBit(1'b1, s, toggle);
    for (int i = 0; i < nBits; i++) sendBit(1'b0, data[7-i], toggle);
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] data, input logic p,
                               input bit toggle, input bit expectAbort);
    exp_t e;
    if (expectAbort) begin
      e = '{4'b0001, mO0, mO1, mCnt, mSat, 1'b1};
      q.push_back(e);
    end
    sendBit(1'b1, s, toggle);
    for (int i = 7; i >= 0; i--) sendBit(1'b0, data[i], toggle);
    if ((^{s, data, p}) == 1'b0) begin
      if (s) mO1 = data;
      else mO0 = data;
      if (mCnt != 8'hFF) mCnt = mCnt + 8'd1;
      if (mSat != 2'd3) mSat = mSat + 2'd1;
      e = '{(s ? 4'b0100 : 4'b1000), mO0, mO1, mCnt, mSat, 1'b0};
    end else begin
      e = '{4'b0010, mO0, mO1, mCnt, mSat, 1'b0};
    end
    q.push_back(e);
    sendBit(1'b0, p, toggle);
  endtask

  task automatic waitDrain();
    @(posedge clk);
    #1;
    en = 1'b0;
    sync = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    checkOutput("drain", q.size(), 32'd0);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b1;
    sync = 1'b0;
    din = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    checkOutput("queueAtReset", q.size(), 32'd0);
    q.delete();
    mO0 = 8'h00;
    mO1 = 8'h00;
    mCnt = 8'h00;
    mSat = 2'd0;
    @(negedge clk);
    checkOutput("rstO0", {24'd0, O0}, 32'd0);
    checkOutput("rstO1", {24'd0, O1}, 32'd0);
    checkOutput("rstCnt", {24'd0, frm_cnt}, 32'd0);
    checkOutput("rstSatCnt", {30'd0, sCnt}, 32'd0);
    checkOutput("rstFlags", {27'd0, v0, v1, perr, abrt, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] d;
    logic       s;
    applyReset();

    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    waitDrain();

    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0);
    waitDrain();

    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    waitDrain();

    sendPartial(1'b1, 8'hAA, 4, 1'b0);
    applyStimulus(1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    waitDrain();

    // Restart arriving while the parity bit is still awaited.
    sendPartial(1'b0, 8'h55, 8, 1'b1);
    applyStimulus(1'b1, 8'h7E, 1'b1, 1'b1, 1'b1);
    waitDrain();

    sendPartial(1'b1, 8'hF0, 5, 1'b0);
    applyReset();

    applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    waitDrain();

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      s = 1'($urandom);
      applyStimulus(s, d, ^{s, d}, bit'(i % 2), 1'b0);
      waitDrain();
    end
    checkOutput("satCntFinal", {30'd0, sCnt}, 32'd3);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      s = 1'($urandom);
      applyStimulus(s, d, 1'($urandom), bit'(i % 2), 1'b0);
    end
    waitDrain();

    checkOutput("finalQueue", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/tdm_demux_2ch.md
Name: tdm_demux_2ch

Overview:
Receive-side counterpart of the team's 2:1 channel mux. Takes a framed, bit-serial time-multiplexed stream carrying a channel-select bit, a DATA_W-bit payload and an even-parity bit. Checks each frame and routes its payload into one of two output registers with a one-cycle valid pulse. Sits at the far end of the serial link, feeding the per-channel consumers.

Parameters:
DATA_W, 8, payload width in bits (min 2, max 32)
CNT_W, 8, width of the saturating good-frame counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  bit strobe; din and sync are sampled only when en=1
sync  input  1  frame start marker, qualified by en
din  input  1  serial data bit, qualified by en
O0  output  DATA_W  last good payload for channel 0
O1  output  DATA_W  last good payload for channel 1
v0  output  1  one-cycle pulse: O0 updated
v1  output  1  one-cycle pulse: O1 updated
perr  output  1  one-cycle pulse: frame dropped on parity mismatch
abrt  output  1  one-cycle pulse: frame aborted by early sync
busy  output  1  high while a frame is in progress (state != IDLE)
frm_cnt  output  CNT_W  count of good frames, saturates at all-ones

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; O0, O1, frm_cnt = 0; v0, v1, perr, abrt, busy = 0; shift register and bit counter cleared. Reset mid-frame discards the partial frame and produces no pulses.
- Cycles with en=0 change no state. Exception: v0, v1, perr and abrt still clear after their single pulse cycle.
- Frame format, in en-cycle order:
  - en-cycle 0: sync=1, din=S (channel select).
  - en-cycles 1..DATA_W: payload, MSB first.
  - en-cycle DATA_W+1: parity bit P.
  - Good frame: XOR(S, payload bits, P) = 0.
- State machine (transitions only on en=1):
  - IDLE: sync=1 -> latch S, clear shift register and bit counter, go to DATA. sync=0 -> stay; din is ignored.
  - DATA: shift din into the shift register LSB and increment the bit counter. After DATA_W bits -> PAR.
  - PAR: sample P and evaluate parity.
    - Good: write the payload to O[S]; v[S]=1 the next cycle; frm_cnt+1, saturating.
    - Bad: O0 and O1 unchanged; perr=1 the next cycle.
    - Either outcome -> IDLE.
  - sync=1 while in DATA or PAR: abrt pulses, the partial frame is discarded, the new frame starts at once (din taken as the new S), state=DATA. This rule takes priority over the normal DATA/PAR action.
- Latency: O[S] and v[S] update on the clk edge that samples P, so v[S] is high for exactly the cycle after that edge.
- Back-to-back frames: sync may arrive on the en-cycle immediately after P. No idle en-cycle is required; the frame is accepted normally.
- v0 and v1 are never high in the same cycle. perr, abrt and v* are mutually exclusive per edge.
- Parity is tracked as a running XOR; there is no combinational path from din to any output.
- frm_cnt saturates at 2^CNT_W-1 and does not wrap. Only rst_n clears it.
- busy = (state != IDLE), registered.

Test Plan:
- Reset, then frame S=1, payload 0xA5, P=1 (5 ones incl. S → P=1) with en held high → O1=0xA5, v1 pulses one cycle right after the P edge, O0=0, frm_cnt=1, busy falls with v1.
- Frame S=0, payload 0x3C, P=1 (wrong, expected 0), en toggling 1/0 → perr pulses once, O0 stays 0, frm_cnt unchanged, no v0.
- Back-to-back frames S=0/0x3C/P=0 then S=1/0xFF/P=1 with no gap → v0, then v1 on the next frame, O0=0x3C, O1=0xFF, frm_cnt+2.
- sync reasserted after 4 payload bits, new frame S=0/0x01/P=1 → abrt pulses on the restart edge, then v0 with O0=0x01, O1 unchanged.
- rst_n=0 for one cycle mid-payload, then a clean S=1/0x80/P=0 frame → all outputs 0 after reset, no pulses from the killed frame, then O1=0x80 with v1.
- CNT_W=2, five good frames → frm_cnt reads 1,2,3,3,3.
